// File: rtl/gp0_axi3_reg_slave_if.sv
// AXI3 bus bundle for the Zynq PS M_AXI_GP0 port as seen by the register slave:
// 12-bit IDs, 4-bit burst length, 32-bit data.  Lock/cache/prot/qos are not
// carried because the register bank has no use for them.
interface gp0_axi3_reg_slave_if;

    // write address channel
    logic [11:0] awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    // write data channel
    logic [11:0] wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    // write response channel
    logic [11:0] bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // read address channel
    logic [11:0] arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    // read data channel
    logic [11:0] rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/gp0_axi3_reg_slave.sv
// Control/status register bank behind the Zynq PS M_AXI_GP0 port.
// PS bursts are broken into single-word accesses on a bank of N_REGS 32-bit
// registers located at byte offset BASE.  The write and read paths are two
// independent state machines, each with one transaction in flight.  Beats that
// use an unsupported size/burst type or fall outside the bank are answered
// with SLVERR instead of touching any register.
module gp0_axi3_reg_slave #(
    parameter int          N_REGS = 16,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic                    aclk,
    input  logic                    areset,
    gp0_axi3_reg_slave_if.slave     s_axi,
    output logic [32*N_REGS-1:0]    reg_q,
    output logic [N_REGS-1:0]       reg_wr
);

    localparam int          IDX_W       = $clog2(N_REGS);
    localparam logic [31:0] SPAN        = 32'(4 * N_REGS);
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] regs [N_REGS];

    // held low through reset and for the first clock after it, so the
    // address channels never advertise ready while reset is asserted
    logic active;

    // write side
    w_state_t    w_state, w_next;
    logic        aw_ready_i, w_ready_i, b_valid_i;
    logic        aw_fire, w_fire;
    logic [11:0] aw_id;
    logic [31:0] aw_addr;
    logic [3:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  w_cnt;
    logic        w_err;
    logic [31:0] w_off;
    logic        w_ok;
    logic [IDX_W-1:0] w_idx;

    // read side
    r_state_t    r_state, r_next;
    logic        ar_ready_i, r_valid_i;
    logic        ar_fire, r_fire;
    logic [11:0] r_id;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [3:0]  r_cnt;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [31:0] ld_addr;
    logic [2:0]  ld_size;
    logic [1:0]  ld_burst;
    logic        ld_last;
    logic [31:0] ld_off;
    logic        ld_ok;
    logic [IDX_W-1:0] ld_idx;

    // wid is not needed: GP0 never interleaves write data
    logic unused_wid;
    assign unused_wid = ^s_axi.wid;

    // bus-ready enable that comes up one clock after reset is released
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) active <= 1'b0;
        else        active <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------

    // write FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // write FSM next state and channel handshake outputs
    always_comb begin
        w_next     = w_state;
        aw_ready_i = 1'b0;
        w_ready_i  = 1'b0;
        b_valid_i  = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_ready_i = active;
                if (active && s_axi.awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                w_ready_i = 1'b1;
                if (s_axi.wvalid && (w_cnt == aw_len)) w_next = W_RESP;
            end
            W_RESP: begin
                b_valid_i = 1'b1;
                if (s_axi.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_fire = aw_ready_i && s_axi.awvalid;
    assign w_fire  = w_ready_i  && s_axi.wvalid;

    // decode of the current write beat; the offset subtraction wraps at 2^32
    // so anything below BASE shows up as a huge offset and fails the range test
    always_comb begin
        w_off = aw_addr - BASE;
        w_ok  = (aw_size == 3'd2) &&
                ((aw_burst == BURST_FIXED) || (aw_burst == BURST_INCR)) &&
                (w_off < SPAN);
        w_idx = w_off[IDX_W+1:2];
    end

    // address latch, beat counting, byte-lane register writes and write pulses
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_id    <= '0;
            aw_addr  <= '0;
            aw_len   <= '0;
            aw_size  <= '0;
            aw_burst <= '0;
            w_cnt    <= '0;
            w_err    <= 1'b0;
            reg_wr   <= '0;
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else begin
            reg_wr <= '0;
            if (aw_fire) begin
                aw_id    <= s_axi.awid;
                aw_addr  <= s_axi.awaddr;
                aw_len   <= s_axi.awlen;
                aw_size  <= s_axi.awsize;
                aw_burst <= s_axi.awburst;
                w_cnt    <= '0;
                w_err    <= 1'b0;
            end
            if (w_fire) begin
                if (w_ok) begin
                    for (int k = 0; k < 4; k++) begin
                        if (s_axi.wstrb[k]) regs[w_idx][8*k +: 8] <= s_axi.wdata[8*k +: 8];
                    end
                    if (|s_axi.wstrb) reg_wr[w_idx] <= 1'b1;
                end else begin
                    w_err <= 1'b1;
                end
                if (s_axi.wlast != (w_cnt == aw_len)) w_err <= 1'b1;
                w_cnt <= w_cnt + 4'd1;
                if (aw_burst == BURST_INCR) aw_addr <= aw_addr + 32'd4;
            end
        end
    end

    assign s_axi.awready = aw_ready_i;
    assign s_axi.wready  = w_ready_i;
    assign s_axi.bvalid  = b_valid_i;
    assign s_axi.bid     = aw_id;
    assign s_axi.bresp   = w_err ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // read FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // read FSM next state and channel handshake outputs
    always_comb begin
        r_next     = r_state;
        ar_ready_i = 1'b0;
        r_valid_i  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready_i = active;
                if (active && s_axi.arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                r_valid_i = 1'b1;
                if (s_axi.rready && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_fire = ar_ready_i && s_axi.arvalid;
    assign r_fire  = r_valid_i  && s_axi.rready;

    // the beat to load next: the first beat straight off the AR channel,
    // otherwise the successor of the beat currently being presented
    always_comb begin
        if (ar_fire) begin
            ld_addr  = s_axi.araddr;
            ld_size  = s_axi.arsize;
            ld_burst = s_axi.arburst;
            ld_last  = (s_axi.arlen == 4'd0);
        end else begin
            ld_addr  = (r_burst == BURST_INCR) ? (r_addr + 32'd4) : r_addr;
            ld_size  = r_size;
            ld_burst = r_burst;
            ld_last  = ((r_cnt + 4'd1) == r_len);
        end
        ld_off = ld_addr - BASE;
        ld_ok  = (ld_size == 3'd2) &&
                 ((ld_burst == BURST_FIXED) || (ld_burst == BURST_INCR)) &&
                 (ld_off < SPAN);
        ld_idx = ld_off[IDX_W+1:2];
    end

    // read beat registers; loading samples regs before any same-edge write lands
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_resp  <= '0;
            r_last  <= 1'b0;
        end else if (ar_fire || (r_fire && !r_last)) begin
            if (ar_fire) begin
                r_id    <= s_axi.arid;
                r_len   <= s_axi.arlen;
                r_size  <= s_axi.arsize;
                r_burst <= s_axi.arburst;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + 4'd1;
            end
            r_addr <= ld_addr;
            r_last <= ld_last;
            r_data <= ld_ok ? regs[ld_idx] : 32'd0;
            r_resp <= ld_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_fire) begin
            r_last <= 1'b0;
            r_data <= '0;
            r_resp <= '0;
        end
    end

    assign s_axi.arready = ar_ready_i;
    assign s_axi.rvalid  = r_valid_i;
    assign s_axi.rid     = r_id;
    assign s_axi.rdata   = r_data;
    assign s_axi.rresp   = r_resp;
    assign s_axi.rlast   = r_last;

    // flat view of the bank for fabric logic
    for (genvar g = 0; g < N_REGS; g++) begin : g_reg_q
        assign reg_q[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_gp0_axi3_reg_slave.sv
// Directed bench for gp0_axi3_reg_slave: drives PS-style bursts through the
// AXI3 interface and compares every response against hand-computed values.
module tb_gp0_axi3_reg_slave;

    localparam int N_REGS = 16;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic [32*N_REGS-1:0]  reg_q;
    logic [N_REGS-1:0]     reg_wr;

    gp0_axi3_reg_slave_if ifc ();

    gp0_axi3_reg_slave #(
        .N_REGS (N_REGS),
        .BASE   (32'h0000_0000)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axi  (ifc.slave),
        .reg_q  (reg_q),
        .reg_wr (reg_wr)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;
    int wr10_cnt = 0;

    logic [31:0]       wdata_v [16];
    logic [3:0]        wstrb_v [16];
    logic [31:0]       exp_rd  [16];
    logic [1:0]        exp_rr  [16];
    logic [N_REGS-1:0] last_reg_wr;
    int                last_w_wait;
    int                last_b_wait;
    logic              first_rvalid;
    logic [11:0]       first_rid;
    logic [1:0]        bresp_got;
    logic [11:0]       bid_got;
    int                base_cnt;

    // counts write pulses on register 10 for the FIXED burst test
    always @(negedge aclk) if (reg_wr[10]) wr10_cnt <= wr10_cnt + 1;

    // safety net so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: run still active at %0t, required completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return reg_q[32*i +: 32];
    endfunction

    // one complete write burst using wdata_v/wstrb_v; last_ok=0 drives wlast inverted
    task automatic apply_write(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic last_ok);
        int n;
        ifc.awid    = id;
        ifc.awaddr  = addr;
        ifc.awlen   = len;
        ifc.awsize  = size;
        ifc.awburst = burst;
        ifc.awvalid = 1'b1;
        n = 0;
        while (!ifc.awready && n < 50) begin @(posedge aclk); #1; n++; end
        check_output("aw_accept", 32'(ifc.awready), 32'd1);
        @(posedge aclk); #1;
        ifc.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            ifc.wdata  = wdata_v[i];
            ifc.wstrb  = wstrb_v[i];
            ifc.wlast  = ((i == int'(len)) == last_ok);
            ifc.wvalid = 1'b1;
            n = 0;
            while (!ifc.wready && n < 50) begin @(posedge aclk); #1; n++; end
            if (i == 0) last_w_wait = n;
            if (!ifc.wready) begin
                check_output("w_accept", 32'(ifc.wready), 32'd1);
                break;
            end
            @(posedge aclk); #1;
        end
        last_reg_wr = reg_wr;
        ifc.wvalid = 1'b0;
        ifc.wlast  = 1'b0;
        n = 0;
        while (!ifc.bvalid && n < 50) begin @(posedge aclk); #1; n++; end
        last_b_wait = n;
        check_output("b_valid", 32'(ifc.bvalid), 32'd1);
        bresp_got  = ifc.bresp;
        bid_got    = ifc.bid;
        ifc.bready = 1'b1;
        @(posedge aclk); #1;
        ifc.bready = 1'b0;
    endtask

    // one complete read burst checked beat by beat against exp_rd/exp_rr;
    // with toggle set rready alternates 1/0 and stalled beats are checked too
    task automatic apply_read(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input logic toggle);
        int n;
        int cyc;
        int beat;
        ifc.arid    = id;
        ifc.araddr  = addr;
        ifc.arlen   = len;
        ifc.arsize  = 3'd2;
        ifc.arburst = burst;
        ifc.arvalid = 1'b1;
        n = 0;
        while (!ifc.arready && n < 50) begin @(posedge aclk); #1; n++; end
        check_output("ar_accept", 32'(ifc.arready), 32'd1);
        @(posedge aclk); #1;
        ifc.arvalid  = 1'b0;
        first_rvalid = ifc.rvalid;
        first_rid    = ifc.rid;
        cyc  = 0;
        beat = 0;
        while (beat <= int'(len) && cyc < 200) begin
            ifc.rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (ifc.rvalid) begin
                check_output($sformatf("rd_b%0d_data", beat), ifc.rdata, exp_rd[beat]);
                check_output($sformatf("rd_b%0d_resp", beat), 32'(ifc.rresp), 32'(exp_rr[beat]));
                check_output($sformatf("rd_b%0d_last", beat), 32'(ifc.rlast), 32'(beat == int'(len)));
                if (ifc.rready) beat++;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        ifc.rready = 1'b0;
        check_output("rd_beats", 32'(beat), 32'(int'(len) + 1));
        check_output("rd_done_rvalid", 32'(ifc.rvalid), 32'd0);
    endtask

    initial begin
        areset      = 1'b1;
        ifc.awid    = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0;
        ifc.awvalid = 1'b0;
        ifc.wid     = '0; ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0;
        ifc.bready  = 1'b0;
        ifc.arid    = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0; ifc.arburst = '0;
        ifc.arvalid = 1'b0;
        ifc.rready  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wdata_v[i] = '0; wstrb_v[i] = 4'hF; exp_rd[i] = '0; exp_rr[i] = 2'b00;
        end

        // reset values
        repeat (3) @(posedge aclk);
        #1;
        check_output("rst_awready", 32'(ifc.awready), 32'd0);
        check_output("rst_arready", 32'(ifc.arready), 32'd0);
        check_output("rst_wready",  32'(ifc.wready),  32'd0);
        check_output("rst_bvalid",  32'(ifc.bvalid),  32'd0);
        check_output("rst_rvalid",  32'(ifc.rvalid),  32'd0);
        check_output("rst_rlast",   32'(ifc.rlast),   32'd0);
        check_output("rst_rdata",   ifc.rdata,        32'd0);
        check_output("rst_resp",    32'({ifc.bresp, ifc.rresp}), 32'd0);
        check_output("rst_ids",     32'({ifc.bid, ifc.rid}),     32'd0);
        check_output("rst_regq",    32'(|reg_q),      32'd0);
        check_output("rst_regwr",   32'(reg_wr),      32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;
        check_output("idle_awready", 32'(ifc.awready), 32'd1);
        check_output("idle_arready", 32'(ifc.arready), 32'd1);

        // single write to 0x10
        $display("[TB] single write");
        wdata_v[0] = 32'hDEADBEEF; wstrb_v[0] = 4'hF;
        apply_write(12'h123, 32'h10, 4'd0, 3'd2, 2'b01, 1'b1);
        check_output("sw_bresp",   32'(bresp_got),   32'd0);
        check_output("sw_bid",     32'(bid_got),     32'h123);
        check_output("sw_reg4",    reg_at(4),        32'hDEADBEEF);
        check_output("sw_regwr",   32'(last_reg_wr), 32'h0010);
        check_output("sw_w_lat",   32'(last_w_wait), 32'd0);
        check_output("sw_b_lat",   32'(last_b_wait), 32'd0);

        // INCR burst with partial strobe on beat 1
        $display("[TB] incr write burst");
        wdata_v[0] = 32'hAAAAAAAA; wstrb_v[0] = 4'hF;
        apply_write(12'h001, 32'h04, 4'd0, 3'd2, 2'b01, 1'b1);
        wdata_v[0] = 32'h11111111; wstrb_v[0] = 4'hF;
        wdata_v[1] = 32'h22222222; wstrb_v[1] = 4'h3;
        wdata_v[2] = 32'h33333333; wstrb_v[2] = 4'hF;
        wdata_v[3] = 32'h44444444; wstrb_v[3] = 4'hF;
        apply_write(12'h002, 32'h00, 4'd3, 3'd2, 2'b01, 1'b1);
        check_output("ib_bresp", 32'(bresp_got), 32'd0);
        check_output("ib_bid",   32'(bid_got),   32'h002);
        check_output("ib_reg0",  reg_at(0),      32'h11111111);
        check_output("ib_reg1",  reg_at(1),      32'hAAAA2222);
        check_output("ib_reg2",  reg_at(2),      32'h33333333);
        check_output("ib_reg3",  reg_at(3),      32'h44444444);
        check_output("ib_regwr", 32'(last_reg_wr), 32'h0008);

        // full-bank INCR read with rready toggling
        $display("[TB] full bank read with stalls");
        wdata_v[0] = 32'hCAFEF00D; wstrb_v[0] = 4'hF;
        apply_write(12'h003, 32'h3C, 4'd0, 3'd2, 2'b01, 1'b1);
        for (int i = 0; i < 16; i++) begin exp_rd[i] = '0; exp_rr[i] = 2'b00; end
        exp_rd[0]  = 32'h11111111;
        exp_rd[1]  = 32'hAAAA2222;
        exp_rd[2]  = 32'h33333333;
        exp_rd[3]  = 32'h44444444;
        exp_rd[4]  = 32'hDEADBEEF;
        exp_rd[15] = 32'hCAFEF00D;
        apply_read(12'h0AB, 32'h00, 4'd15, 2'b01, 1'b1);
        check_output("fr_r_lat", 32'(first_rvalid), 32'd1);
        check_output("fr_rid",   32'(first_rid),    32'h0AB);

        // read across the top of the bank
        $display("[TB] read past end of bank");
        exp_rd[0] = 32'hCAFEF00D; exp_rr[0] = 2'b00;
        exp_rd[1] = 32'h0;        exp_rr[1] = 2'b10;
        apply_read(12'h007, 32'h3C, 4'd1, 2'b01, 1'b0);

        // unsupported size and WRAP bursts
        $display("[TB] unsupported size and burst");
        wdata_v[0] = 32'hFFFFFFFF; wstrb_v[0] = 4'hF;
        wdata_v[1] = 32'hFFFFFFFF; wstrb_v[1] = 4'hF;
        apply_write(12'h004, 32'h20, 4'd0, 3'd1, 2'b01, 1'b1);
        check_output("sz_bresp",  32'(bresp_got),   32'h2);
        check_output("sz_reg8",   reg_at(8),        32'h0);
        check_output("sz_regwr",  32'(last_reg_wr), 32'h0);
        apply_write(12'h005, 32'h24, 4'd1, 3'd2, 2'b10, 1'b1);
        check_output("wrap_bresp", 32'(bresp_got),  32'h2);
        check_output("wrap_reg9",  reg_at(9),       32'h0);

        // FIXED burst hits one register three times
        $display("[TB] fixed write burst");
        base_cnt = wr10_cnt;
        wdata_v[0] = 32'h00000001; wdata_v[1] = 32'h00000002; wdata_v[2] = 32'h00000003;
        wstrb_v[0] = 4'hF; wstrb_v[1] = 4'hF; wstrb_v[2] = 4'hF;
        apply_write(12'h006, 32'h28, 4'd2, 3'd2, 2'b00, 1'b1);
        check_output("fx_bresp",  32'(bresp_got),           32'd0);
        check_output("fx_reg10",  reg_at(10),               32'h3);
        check_output("fx_reg11",  reg_at(11),               32'h0);
        check_output("fx_pulses", 32'(wr10_cnt - base_cnt), 32'd3);

        // wlast in the wrong place still completes on the beat count
        $display("[TB] wlast mismatch");
        wdata_v[0] = 32'h12121212; wstrb_v[0] = 4'hF;
        apply_write(12'h00C, 32'h30, 4'd0, 3'd2, 2'b01, 1'b0);
        check_output("wl_bresp", 32'(bresp_got), 32'h2);
        check_output("wl_reg12", reg_at(12),     32'h12121212);

        // concurrent write and FIXED read of register 6: the second read beat
        // loads on the same edge as the write commit and must see the old value
        $display("[TB] concurrent read and write");
        wdata_v[0] = 32'h00000066; wstrb_v[0] = 4'hF;
        exp_rd[0] = 32'h0; exp_rr[0] = 2'b00;
        exp_rd[1] = 32'h0; exp_rr[1] = 2'b00;
        fork
            apply_write(12'h008, 32'h18, 4'd0, 3'd2, 2'b01, 1'b1);
            apply_read(12'h009, 32'h18, 4'd1, 2'b00, 1'b0);
        join
        check_output("cc_bresp", 32'(bresp_got), 32'd0);
        check_output("cc_reg6",  reg_at(6),      32'h66);
        exp_rd[0] = 32'h00000066; exp_rr[0] = 2'b00;
        apply_read(12'h00A, 32'h18, 4'd0, 2'b01, 1'b0);

        // INCR read wrapping the 32-bit address space back into the bank
        $display("[TB] address wrap");
        exp_rd[0] = 32'h0;        exp_rr[0] = 2'b10;
        exp_rd[1] = 32'h11111111; exp_rr[1] = 2'b00;
        apply_read(12'h00B, 32'hFFFFFFFC, 4'd1, 2'b01, 1'b0);

        // asynchronous reset in the middle of a read and a write burst
        $display("[TB] reset mid-burst");
        ifc.arid = 12'h00E; ifc.araddr = 32'h0; ifc.arlen = 4'd15; ifc.arsize = 3'd2;
        ifc.arburst = 2'b01; ifc.arvalid = 1'b1;
        ifc.awid = 12'h00F; ifc.awaddr = 32'h0; ifc.awlen = 4'd3; ifc.awsize = 3'd2;
        ifc.awburst = 2'b01; ifc.awvalid = 1'b1;
        @(posedge aclk); #1;
        ifc.arvalid = 1'b0;
        ifc.awvalid = 1'b0;
        ifc.wdata = 32'h55555555; ifc.wstrb = 4'hF; ifc.wlast = 1'b0; ifc.wvalid = 1'b1;
        @(posedge aclk); #1;
        ifc.wvalid = 1'b0;
        check_output("mr_pre_rvalid", 32'(ifc.rvalid), 32'd1);
        check_output("mr_pre_wready", 32'(ifc.wready), 32'd1);
        check_output("mr_pre_reg0",   reg_at(0),       32'h55555555);
        check_output("mr_pre_regwr",  32'(reg_wr),     32'h0001);
        #2 areset = 1'b1;
        #1;
        check_output("mr_awready", 32'(ifc.awready), 32'd0);
        check_output("mr_arready", 32'(ifc.arready), 32'd0);
        check_output("mr_wready",  32'(ifc.wready),  32'd0);
        check_output("mr_bvalid",  32'(ifc.bvalid),  32'd0);
        check_output("mr_rvalid",  32'(ifc.rvalid),  32'd0);
        check_output("mr_rlast",   32'(ifc.rlast),   32'd0);
        check_output("mr_rdata",   ifc.rdata,        32'd0);
        check_output("mr_ids",     32'({ifc.bid, ifc.rid}), 32'd0);
        check_output("mr_regq",    32'(|reg_q),      32'd0);
        check_output("mr_regwr",   32'(reg_wr),      32'd0);
        repeat (2) @(posedge aclk);
        #3 areset = 1'b0;
        @(posedge aclk); #1;

        // normal operation after reset release
        $display("[TB] recovery after reset");
        wdata_v[0] = 32'h0BADF00D; wstrb_v[0] = 4'hF;
        apply_write(12'h010, 32'h08, 4'd0, 3'd2, 2'b01, 1'b1);
        check_output("rc_bresp", 32'(bresp_got), 32'd0);
        check_output("rc_reg2",  reg_at(2),      32'h0BADF00D);
        check_output("rc_reg0",  reg_at(0),      32'h0);
        exp_rd[0] = 32'h0BADF00D; exp_rr[0] = 2'b00;
        apply_read(12'h011, 32'h08, 4'd0, 2'b01, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
